// File: rtl/jogador_automatico.sv
// Automatic player for the memory game: records the jogadas shown on leds,
// then replays them on chaves as timed presses, with optional error injection.
module jogador_automatico #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 3,
  parameter int START_DELAY = 5,
  parameter int ADDR_W      = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ativo,
  input  logic [3:0]        leds,
  input  logic              vez_jogador,
  input  logic              acertou,
  input  logic              errou,
  input  logic              timeout,
  input  logic              injetar_erro,
  input  logic [ADDR_W-1:0] indice_erro,
  output logic [3:0]        chaves,
  output logic              ocupado,
  output logic [ADDR_W:0]   jogadas_capturadas,
  output logic              overflow,
  output logic [3:0]        db_estado
);

  typedef enum logic [3:0] {
    OCIOSO    = 4'd0,
    CAPTURA   = 4'd1,
    ESPERA    = 4'd2,
    PRESSIONA = 4'd3,
    SOLTA     = 4'd4,
    AGUARDA   = 4'd5,
    FIM       = 4'd6
  } estado_t;

  localparam int T_HG  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int T_MAX = (T_HG > START_DELAY) ? T_HG : START_DELAY;
  localparam int TW    = $clog2(T_MAX + 1);

  estado_t           r_estado;
  logic [ADDR_W:0]   r_wr_ptr;
  logic [ADDR_W:0]   r_rd_ptr;
  logic [TW-1:0]     r_timer;
  logic              r_overflow;
  logic [3:0]        r_leds_prev;
  logic              r_vez_prev;
  logic [3:0]        r_chaves;
  logic              r_ocupado;
  logic [3:0]        r_mem [DEPTH];

  estado_t           w_estado_prox;
  logic [ADDR_W:0]   w_wr_ptr_prox;
  logic [ADDR_W:0]   w_rd_ptr_prox;
  logic [TW-1:0]     w_timer_prox;
  logic              w_overflow_prox;
  logic              w_escreve;
  logic [3:0]        w_chaves_prox;

  logic              w_borda_leds;
  logic              w_sobe_vez;
  logic              w_fim;
  logic              w_timer_fim;
  logic              w_cheio;
  logic [3:0]        w_dado;
  logic [3:0]        w_dado_saida;

  assign w_borda_leds = (r_leds_prev == 4'b0000) && (leds != 4'b0000);
  assign w_sobe_vez   = !r_vez_prev && vez_jogador;
  assign w_fim        = acertou || errou || timeout;
  assign w_timer_fim  = (r_timer <= TW'(1));
  assign w_cheio      = (r_wr_ptr >= (ADDR_W+1)'(DEPTH));
  assign w_dado       = r_mem[r_rd_ptr[ADDR_W-1:0]];
  // Injected error rotates the key left: {b2,b1,b0,b3}
  assign w_dado_saida = (injetar_erro && (r_rd_ptr == {1'b0, indice_erro}))
                        ? {w_dado[2:0], w_dado[3]} : w_dado;

  always_comb begin
    w_estado_prox   = r_estado;
    w_wr_ptr_prox   = r_wr_ptr;
    w_rd_ptr_prox   = r_rd_ptr;
    w_timer_prox    = r_timer;
    w_overflow_prox = r_overflow;
    w_escreve       = 1'b0;
    if (!ativo) begin
      w_estado_prox = OCIOSO;
    end else if ((r_estado != OCIOSO) && w_fim) begin
      w_estado_prox = FIM;
    end else begin
      case (r_estado)
        OCIOSO: begin
          w_estado_prox   = CAPTURA;
          w_wr_ptr_prox   = '0;
          w_overflow_prox = 1'b0;
        end
        CAPTURA: begin
          // Capture is resolved before the vez rise so a same-cycle jogada counts
          if (w_borda_leds && !w_cheio) begin
            w_escreve     = 1'b1;
            w_wr_ptr_prox = r_wr_ptr + (ADDR_W+1)'(1);
          end else if (w_borda_leds) begin
            w_overflow_prox = 1'b1;
          end else begin
            w_escreve = 1'b0;
          end
          if (w_sobe_vez && (w_wr_ptr_prox == '0)) begin
            w_estado_prox = AGUARDA;
          end else if (w_sobe_vez) begin
            w_estado_prox = ESPERA;
            w_rd_ptr_prox = '0;
            w_timer_prox  = TW'(START_DELAY);
          end else begin
            w_estado_prox = CAPTURA;
          end
        end
        ESPERA: begin
          if (!vez_jogador) begin
            w_estado_prox = CAPTURA;
            w_wr_ptr_prox = '0;
          end else if (w_timer_fim) begin
            w_estado_prox = PRESSIONA;
            w_timer_prox  = TW'(HOLD_CYCLES);
          end else begin
            w_timer_prox = r_timer - TW'(1);
          end
        end
        PRESSIONA: begin
          if (!vez_jogador) begin
            w_estado_prox = CAPTURA;
            w_wr_ptr_prox = '0;
          end else if (w_timer_fim) begin
            w_estado_prox = SOLTA;
            w_timer_prox  = TW'(GAP_CYCLES);
          end else begin
            w_timer_prox = r_timer - TW'(1);
          end
        end
        SOLTA: begin
          if (!vez_jogador) begin
            w_estado_prox = CAPTURA;
            w_wr_ptr_prox = '0;
          end else if (w_timer_fim) begin
            w_rd_ptr_prox = r_rd_ptr + (ADDR_W+1)'(1);
            if ((r_rd_ptr + (ADDR_W+1)'(1)) == r_wr_ptr) begin
              w_estado_prox = AGUARDA;
            end else begin
              w_estado_prox = PRESSIONA;
              w_timer_prox  = TW'(HOLD_CYCLES);
            end
          end else begin
            w_timer_prox = r_timer - TW'(1);
          end
        end
        AGUARDA: begin
          if (!vez_jogador) begin
            w_estado_prox = CAPTURA;
            w_wr_ptr_prox = '0;
          end else begin
            w_estado_prox = AGUARDA;
          end
        end
        FIM: begin
          w_estado_prox = FIM;
        end
        default: begin
          w_estado_prox = OCIOSO;
        end
      endcase
    end
  end

  // Keys are driven only while a press continues; abort, FIM and ativo=0 drop them at once
  always_comb begin
    w_chaves_prox = 4'b0000;
    if ((r_estado == PRESSIONA) && ativo && vez_jogador && !w_fim) begin
      w_chaves_prox = w_dado_saida;
    end else begin
      w_chaves_prox = 4'b0000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_timer     <= '0;
      r_overflow  <= 1'b0;
      r_leds_prev <= 4'b0000;
      r_vez_prev  <= 1'b0;
      r_chaves    <= 4'b0000;
      r_ocupado   <= 1'b0;
    end else begin
      r_estado    <= w_estado_prox;
      r_wr_ptr    <= w_wr_ptr_prox;
      r_rd_ptr    <= w_rd_ptr_prox;
      r_timer     <= w_timer_prox;
      r_overflow  <= w_overflow_prox;
      r_leds_prev <= leds;
      r_vez_prev  <= vez_jogador;
      r_chaves    <= w_chaves_prox;
      r_ocupado   <= (w_estado_prox == ESPERA) || (w_estado_prox == PRESSIONA) ||
                     (w_estado_prox == SOLTA);
    end
  end

  always_ff @(posedge clock) begin
    if (w_escreve) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= leds;
    end
  end

  assign chaves             = r_chaves;
  assign ocupado            = r_ocupado;
  assign jogadas_capturadas = r_wr_ptr;
  assign overflow           = r_overflow;
  assign db_estado          = r_estado;

endmodule

// File: doc/jogador_automatico.md
Name: jogador_automatico

Overview:
- Automatic player for the memory-game circuit (circuito_exp6 family); acts as the opposite end of its leds/chaves interface.
- Watches `leds` while the game presents a round and records each presented jogada in an internal buffer.
- When `vez_jogador` rises, it replays the recorded sequence on `chaves` as timed press/release pulses.
- Used in hardware self-test and in benches in place of a human player; it can inject a deliberate error at a chosen jogada.

Parameters:
- DEPTH, 16: max jogadas stored per round; ADDR_W = $clog2(DEPTH).
- HOLD_CYCLES, 3: clock cycles `chaves` stays driven per press.
- GAP_CYCLES, 3: clock cycles `chaves` = 0 after each press.
- START_DELAY, 5: cycles waited after `vez_jogador` rises before the first press.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- ativo  input  1  enable; 0 forces OCIOSO.
- leds  input  4  game LED output, one-hot during presentation.
- vez_jogador  input  1  game waiting for player input.
- acertou  input  1  game won.
- errou  input  1  game lost.
- timeout  input  1  game timed out.
- injetar_erro  input  1  enable error injection.
- indice_erro  input  ADDR_W  jogada index (0-based) to corrupt.
- chaves  output  4  player key outputs to the game.
- ocupado  output  1  high in ESPERA, PRESSIONA, SOLTA.
- jogadas_capturadas  output  ADDR_W+1  count recorded this round.
- overflow  output  1  sticky; a capture was attempted with the buffer full.
- db_estado  output  4  state encoding, for debug.

Behaviour:
- Reset (async, active-high): state OCIOSO; chaves=0, ocupado=0, jogadas_capturadas=0, overflow=0, wr_ptr=rd_ptr=0, leds_prev=0, vez_prev=0.
- Registers leds_prev and vez_prev update every cycle in all states.
- Registered outputs: `chaves` changes on the clock edge after the state enters or leaves PRESSIONA.
- OCIOSO (0): chaves=0. If ativo=1, go to CAPTURA with wr_ptr=0 and overflow=0.
- CAPTURA (1), capture edge (leds_prev==0 and leds!=0):
  - If wr_ptr<DEPTH: mem[wr_ptr]<=leds and wr_ptr++.
  - Otherwise set overflow=1 and keep wr_ptr.
  - Non-one-hot values are stored as-is.
- CAPTURA, vez_jogador rise (vez_prev=0, vez_jogador=1):
  - If wr_ptr==0, go to AGUARDA.
  - Otherwise go to ESPERA with rd_ptr=0 and the timer loaded with START_DELAY.
  - If the capture edge and the vez rise occur in the same cycle, the capture is taken first and counts.
- ESPERA (2): after START_DELAY cycles, go to PRESSIONA and load the timer.
- PRESSIONA (3):
  - chaves = mem[rd_ptr].
  - If injetar_erro=1 and rd_ptr==indice_erro, chaves = mem[rd_ptr] rotated left by 1 ({b2,b1,b0,b3}).
  - After HOLD_CYCLES cycles, go to SOLTA.
- SOLTA (4):
  - chaves=0 for GAP_CYCLES cycles, then rd_ptr++.
  - If rd_ptr+1 == wr_ptr, go to AGUARDA; otherwise go to PRESSIONA.
- AGUARDA (5): chaves=0. When vez_jogador=0, go to CAPTURA with wr_ptr=0; the buffer is re-filled each round.
- Abort: vez_jogador falls while in ESPERA, PRESSIONA or SOLTA → CAPTURA with wr_ptr=0, and chaves=0 on the next cycle.
- FIM (6):
  - Entered from any state except OCIOSO when acertou, errou or timeout is 1.
  - Priority: FIM over every other transition.
  - chaves=0. Leaves to OCIOSO only when ativo=0.
- ativo=0 in any state → OCIOSO next cycle; chaves=0.
- jogadas_capturadas mirrors wr_ptr.
- overflow clears only on reset or when entering CAPTURA from OCIOSO.
- Press timing: press-to-press period = HOLD_CYCLES+GAP_CYCLES (6 cycles at defaults). Timer is a down-counter sized to max(HOLD,GAP,START_DELAY).

Test Plan:
- Reset mid-press: assert reset while chaves=4'b0010 → chaves=0 immediately (async), state OCIOSO, jogadas_capturadas=0.
- Single-round capture: ativo=1; leds shows 0001 for 1000 cycles, then 0; vez_jogador rises → after 5 cycles chaves=0001 for exactly 3 cycles, then 0; state AGUARDA; jogadas_capturadas=1.
- Three-jogada round: leds shows 0001, 0, 0010, 0, 0100, then vez rises → chaves sequence 0001, 0010, 0100, each 3 on / 3 off; the second press starts 6 cycles after the first.
- Error injection: same stimulus with injetar_erro=1 and indice_erro=1 → second press is 0100 (0010 rotated); errou asserted → FIM, chaves=0 held until ativo=0.
- Overflow and abort:
  - DEPTH=4 with 5 leds pulses → overflow=1 and jogadas_capturadas=4.
  - Drop vez_jogador during the second press → chaves=0 next cycle; state CAPTURA; jogadas_capturadas=0.
- Full game with circuito_exp6 (nivel_jogadas=0, nivel_tempo=0): player wins all rounds; acertou=1, errou=0, timeout=0; FIM reached.
